axi_read_master: RTL
====================

AXI_READ_MASTER -- requirements
Module: axi_read_master

Interface
REQ-001 SHALL have parameter BusWidth, default 32, meaning address/data width.
REQ-002 SHALL have parameter tagbits, default 2, meaning transaction ID width.
REQ-003 SHALL have ports: ACLK in 1, the single clock, all logic on rising edge; ARESETn in 1, asynchronous active-low reset.
REQ-004 SHALL have local request ports: req_valid in 1; req_ready out 1; req_id in tagbits; req_addr in BusWidth; req_len in 4 (beats-1); req_size in 2; req_burst in 2.
REQ-005 SHALL have local return ports: rd_valid out 1; rd_ready in 1; rd_data out BusWidth; rd_id out tagbits; rd_resp out 2; rd_last out 1; busy out 1; err out 1 (sticky protocol error).
REQ-006 SHALL have AR ports: ARID out tagbits; ARADDR out BusWidth; ARLEN out 4; ARSIZE out 2; ARBURST out 2; ARLOCK out 2; ARCACHE out 4; ARPROT out 3; ARVALID out 1; ARREADY in 1.
REQ-007 SHALL have R ports: RID in tagbits; RDATA in BusWidth; RRESP in 2; RLAST in 1; RVALID in 1; RREADY out 1.

Function
REQ-008 SHALL implement states IDLE, ADDR, DATA; one outstanding transaction at a time.
REQ-009 req_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-010 IDLE: on req_valid&&req_ready, latch id/addr/len/size/burst, clear err, go to ADDR; ARVALID high from the next cycle.
REQ-011 Latched ARLEN SHALL be {2'b00, req_len[1:0]} (max 4 beats); req_size 2'b11 SHALL be clamped to 2'b10; req_burst passed unchanged.
REQ-012 ARLOCK, ARCACHE, ARPROT SHALL be driven constant 0.
REQ-013 ADDR: ARVALID held high and all AR outputs held stable until a rising edge with ARREADY=1; then ARVALID=0 and go to DATA; ARVALID SHALL NOT depend combinationally on ARREADY.
REQ-014 RREADY SHALL equal (state==DATA) && (!rd_valid || rd_ready) (single-entry output register).
REQ-015 An R beat is accepted on an edge with RVALID&&RREADY; RDATA/RID/RRESP/RLAST captured into rd_data/rd_id/rd_resp/rd_last and rd_valid set the same edge (one-cycle latency).
REQ-016 rd_valid SHALL clear on an edge with rd_ready=1 unless a new beat is captured on that edge; rd_* SHALL hold stable while rd_valid&&!rd_ready.
REQ-017 A 3-bit beat counter SHALL reset to 0 on entering ADDR, increment per accepted beat, and saturate at 7.
REQ-018 err SHALL set on an accepted beat when: RID != latched ID; RLAST=1 with counter != ARLEN[1:0]; or RLAST=0 with counter >= ARLEN[1:0].
REQ-019 Erroneous beats SHALL still be forwarded unchanged; err holds until the next request is accepted.
REQ-020 DATA SHALL return to IDLE on the edge accepting a beat with RLAST=1; a beat count mismatch SHALL NOT end the transaction.
REQ-021 Next request SHALL be accepted no earlier than the cycle after returning to IDLE; a pending rd_valid in IDLE SHALL drain normally.
REQ-022 RVALID outside DATA SHALL be ignored (RREADY low, no capture, no err).

Reset
REQ-023 ARESETn low SHALL immediately force state IDLE, counter 0, and ARVALID, RREADY, rd_valid, rd_last, err, busy, and all AR/rd data outputs to 0; req_ready is 1 in reset.
REQ-024 Reset mid-transaction SHALL abort it with no further beat forwarded; first request is accepted on the first edge after ARESETn rises.

Verification
REQ-025 Single beat: req id=1, addr=0x100, len=0, size=2 -> ARVALID next cycle, ARADDR=0x100, ARLEN=0; ARREADY delayed 3 cycles -> AR held stable; RDATA=0xDEADBEEF, RLAST=1 -> rd_valid one cycle later, rd_last=1, err=0, IDLE.
REQ-026 4-beat INCR, rd_ready low 2 cycles after beat 2 -> RREADY low while buffer full, no beat lost, 4 beats in order, rd_last only on beat 4.
REQ-027 req_len=7, req_size=3 -> ARLEN=3, ARSIZE=2.
REQ-028 len=3, slave asserts RLAST on beat 2 -> err=1, return to IDLE; next request clears err.
REQ-029 RID=2 for request id=1 -> err=1, data forwarded; RVALID=1 while IDLE -> RREADY=0, no rd_valid.
REQ-030 ARESETn low during DATA after beat 1 -> ARVALID/RREADY/rd_valid 0 immediately; new request after release completes normally.

Source files
------------

// File: rtl/axi_read_master.sv
// AXI3-style read master: accepts one local read request at a time, issues it
// on AR, forwards each R beat through a single-entry output register and
// flags protocol violations (wrong ID, early/late RLAST) in a sticky err bit.
module axi_read_master #(
    parameter int BusWidth = 32,
    parameter int tagbits  = 2
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    // local request
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [tagbits-1:0]  req_id,
    input  logic [BusWidth-1:0] req_addr,
    input  logic [3:0]          req_len,
    input  logic [1:0]          req_size,
    input  logic [1:0]          req_burst,
    // local return
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [BusWidth-1:0] rd_data,
    output logic [tagbits-1:0]  rd_id,
    output logic [1:0]          rd_resp,
    output logic                rd_last,
    output logic                busy,
    output logic                err,
    // AR channel
    output logic [tagbits-1:0]  ARID,
    output logic [BusWidth-1:0] ARADDR,
    output logic [3:0]          ARLEN,
    output logic [1:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic [1:0]          ARLOCK,
    output logic [3:0]          ARCACHE,
    output logic [2:0]          ARPROT,
    output logic                ARVALID,
    input  logic                ARREADY,
    // R channel
    input  logic [tagbits-1:0]  RID,
    input  logic [BusWidth-1:0] RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state_q, state_d;
    logic [tagbits-1:0]    id_q, id_d;
    logic [BusWidth-1:0]   addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [BusWidth-1:0]   rd_data_q, rd_data_d;
    logic [tagbits-1:0]    rd_id_q, rd_id_d;
    logic [1:0]            rd_resp_q, rd_resp_d;
    logic                  rd_last_q, rd_last_d;
    logic                  r_fire;
    logic [2:0]            last_idx;

    // AR outputs come straight from the latched request; ARVALID is pure state.
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign ARVALID   = (state_q == ADDR);
    assign ARID      = id_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = size_q;
    assign ARBURST   = burst_q;
    assign ARLOCK    = 2'b00;
    assign ARCACHE   = 4'b0000;
    assign ARPROT    = 3'b000;
    // Accept a beat only when the output register is empty or draining now.
    assign RREADY    = (state_q == DATA) && (!rd_valid_q || rd_ready);
    assign r_fire    = RVALID && RREADY;
    assign last_idx  = {1'b0, len_q[1:0]};

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_id     = rd_id_q;
    assign rd_resp   = rd_resp_q;
    assign rd_last   = rd_last_q;
    assign err       = err_q;

    // Next-state, request latch, beat capture and error detection.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_id_d    = rd_id_q;
        rd_resp_d  = rd_resp_q;
        rd_last_d  = rd_last_q;

        // Consumer drains the output register; a capture below overrides.
        if (rd_ready) rd_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    id_d    = req_id;
                    addr_d  = req_addr;
                    len_d   = {2'b00, req_len[1:0]};
                    // 8-byte beats are not supported on this bus; clamp to 4.
                    size_d  = (req_size == 2'b11) ? 2'b10 : req_size;
                    burst_d = req_burst;
                    err_d   = 1'b0;
                    cnt_d   = 3'd0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ARREADY) state_d = DATA;
            end
            DATA: begin
                if (r_fire) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = RDATA;
                    rd_id_d    = RID;
                    rd_resp_d  = RRESP;
                    rd_last_d  = RLAST;
                    if ((RID != id_q) ||
                        ( RLAST && (cnt_q != last_idx)) ||
                        (!RLAST && (cnt_q >= last_idx)))
                        err_d = 1'b1;
                    if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
                    // Only RLAST ends the burst, even if the count is wrong.
                    if (RLAST) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_id_q    <= '0;
            rd_resp_q  <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_id_q    <= rd_id_d;
            rd_resp_q  <= rd_resp_d;
            rd_last_q  <= rd_last_d;
        end
    end

endmodule
